serial_addsub_unit: RTL and testbench

Multi-cycle, digit-serial n-bit two's-complement adder/subtractor with a start/done handshake and a full status-flag set: carry, overflow, zero and negative. It processes D bits per clock, so width and area/latency trade off through parameters. It is the registered successor of the combinational adder/subtractor and sits in the datapath as the arithmetic unit driven by the control sequencer.

---
 rtl/serial_addsub_unit.sv | 107 ++++++++++
 tb/tb_serial_addsub_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_unit.sv
// Digit-serial N-bit two's-complement adder/subtractor, D bits per clock.
// Start/Done handshake; result and flags are registered and change only when Done fires.
module serial_addsub_unit #(
  parameter int N = 8,
  parameter int D = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_sub,
  input  logic         i_cin,
  input  logic [N-1:0] i_x,
  input  logic [N-1:0] i_y,
  output logic [N-1:0] o_s,
  output logic         o_cout,
  output logic         o_v,
  output logic         o_z,
  output logic         o_neg,
  output logic         o_busy,
  output logic         o_done
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_bad_params
    $error("serial_addsub_unit: N must be >= 2 and a multiple of D, 1 <= D <= N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_x;
  logic [N-1:0]  r_ye;
  logic [N-1:0]  r_res;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  int            w_lsb;
  logic [D:0]    w_sum;
  logic [N-1:0]  w_res;
  logic          w_last;

  // Sum of the current digit; w_res is the result register with that digit merged in,
  // so the final digit can be published on the same edge that enters DONE.
  always_comb begin
    w_lsb  = int'(r_cnt) * D;
    w_sum  = {1'b0, r_x[w_lsb +: D]} + {1'b0, r_ye[w_lsb +: D]} + {{D{1'b0}}, r_carry};
    w_res  = r_res;
    w_res[w_lsb +: D] = w_sum[D-1:0];
    w_last = (r_cnt == LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_ye    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      o_s     <= '0;
      o_cout  <= 1'b0;
      o_v     <= 1'b0;
      o_z     <= 1'b0;
      o_neg   <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        RUN: begin
          r_res   <= w_res;
          r_carry <= w_sum[D];
          if (w_last) begin
            r_state <= DONE;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            o_s     <= w_res;
            o_cout  <= w_sum[D];
            o_v     <= (r_x[N-1] == r_ye[N-1]) && (w_res[N-1] != r_x[N-1]);
            o_z     <= (w_res == '0);
            o_neg   <= w_res[N-1];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE->RUN gives back-to-back operation
          if (i_start) begin
            r_state <= RUN;
            o_busy  <= 1'b1;
            r_x     <= i_x;
            r_ye    <= i_sub ? ~i_y : i_y;
            r_carry <= i_sub ^ i_cin;
            r_res   <= '0;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: four instances (N=8, D=1/2/4/8) share one stimulus
// stream and are compared every cycle against an arithmetic reference model.
module tb_serial_addsub_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic       cin = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;

  logic [3:0][7:0] s_o;
  logic [3:0]      cout_o, v_o, z_o, neg_o, busy_o, done_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_addsub_unit #(.N(8), .D(1 << g)) u_dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_start(start),
      .i_sub  (sub),
      .i_cin  (cin),
      .i_x    (x),
      .i_y    (y),
      .o_s    (s_o[g]),
      .o_cout (cout_o[g]),
      .o_v    (v_o[g]),
      .o_z    (z_o[g]),
      .o_neg  (neg_o[g]),
      .o_busy (busy_o[g]),
      .o_done (done_o[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; returns {s, cout, v, z, neg}
  function automatic logic [11:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                         input logic is_sub, input logic ci);
    int sa, sbv, r, u;
    logic [7:0] s;
    logic co, ov;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (is_sub) begin
      r  = sa - sbv - int'(ci);
      u  = int'(a) - int'(b) - int'(ci);
      co = (u >= 0);
    end else begin
      r  = sa + sbv + int'(ci);
      u  = int'(a) + int'(b) + int'(ci);
      co = (u > 255);
    end
    s  = 8'(u & 255);
    ov = (r > 127) || (r < -128);
    return {s, co, ov, (s == 8'd0), s[7]};
  endfunction

  int               m_rem[4] = '{0, 0, 0, 0};
  logic [3:0][11:0] m_res = '0;
  logic [3:0][11:0] p_res = '0;
  logic [3:0]       m_busy = '0;
  logic [3:0]       m_done = '0;

  // Model: an accepted request publishes its result 8/D edges later with a one-cycle Done
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) m_rem[k] = 0;
      m_res  = '0;
      p_res  = '0;
      m_busy = '0;
      m_done = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (m_rem[k] > 0) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_res[k]  = p_res[k];
            m_busy[k] = 1'b0;
            m_done[k] = 1'b1;
          end
        end else begin
          m_done[k] = 1'b0;
          if (start) begin
            p_res[k]  = ref_op(x, y, sub, cin);
            m_rem[k]  = 8 >> k;
            m_busy[k] = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++)
      chk($sformatf("cycle_d%0d", 1 << k),
          32'({s_o[k], cout_o[k], v_o[k], z_o[k], neg_o[k], busy_o[k], done_o[k]}),
          32'({m_res[k], m_busy[k], m_done[k]}));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic is_sub,
                       input logic ci, input logic [7:0] es, input logic ec,
                       input logic ev, input logic ez, input logic en);
    int lat[4] = '{0, 0, 0, 0};
    x = a; y = b; sub = is_sub; cin = ci; start = 1'b1;
    step();
    start = 1'b0; x = ~a; y = ~b; sub = ~is_sub; cin = ~ci;
    for (int c = 1; c <= 12; c++) begin
      step();
      for (int k = 0; k < 4; k++)
        if (done_o[k] && lat[k] == 0) lat[k] = c;
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("latency_d%0d", 1 << k), 32'(lat[k]), 32'(8 >> k));
      chk($sformatf("result_d%0d", 1 << k),
          32'({s_o[k], cout_o[k], v_o[k], z_o[k], neg_o[k]}), 32'({es, ec, ev, ez, en}));
    end
  endtask

  initial begin
    int ndone;
    int last[4] = '{-1, -1, -1, -1};
    int per[4]  = '{9, 5, 3, 2};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("reset_s", 32'(s_o), 32'd0);
    chk("reset_flags", 32'({cout_o, v_o, z_o, neg_o, busy_o, done_o}), 32'd0);

    chk("model_pin_add", 32'(ref_op(8'h7F, 8'h01, 1'b0, 1'b0)), 32'({8'h80, 4'b0101}));
    chk("model_pin_sub", 32'(ref_op(8'h80, 8'h01, 1'b1, 1'b0)), 32'({8'h7F, 4'b1100}));

    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    do_op(8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    // abort in the middle of a D=1 operation
    x = 8'h12; y = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("abort_s", 32'(s_o), 32'd0);
    chk("abort_flags", 32'({cout_o, v_o, z_o, neg_o, busy_o, done_o}), 32'd0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      step();
      if (done_o[0]) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    do_op(8'h9C, 8'h2B, 1'b1, 1'b1, 8'h70, 1'b1, 1'b1, 1'b0, 1'b0);

    // Start held high, operands scrambled every cycle
    start = 1'b1;
    for (int c = 0; c < 9000; c++) begin
      x   = 8'($urandom);
      y   = 8'($urandom);
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      step();
      for (int k = 0; k < 4; k++)
        if (done_o[k]) begin
          if (last[k] >= 0) chk($sformatf("period_d%0d", 1 << k), 32'(c - last[k]), 32'(per[k]));
          last[k] = c;
        end
    end
    start = 1'b0;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
